ex_muldiv_unit: RTL and testbench

EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

---
 rtl/ex_muldiv_unit.sv | 169 ++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_unit
// Description : Iterative MIPS-style HI/LO multiply/divide unit, radix-2,
//               fixed 33-edge latency with pipeline stall request.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] read_data1,
    input  logic [31:0] read_data2,
    input  logic        flush,
    input  logic        hilo_read,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        busy,
    output logic        done,
    output logic        stall
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [5:0] c_LAST_ITER = 6'd31;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [63:0] r_acc;
    logic [31:0] r_opnd;
    logic [31:0] r_dividend;
    logic        r_is_div;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_div_zero;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic        r_done;

    // Operand conditioning at start: signed ops work on magnitudes
    logic        w_signed;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;

    assign w_signed = ~op[0];
    assign w_neg_a  = w_signed & read_data1[31];
    assign w_neg_b  = w_signed & read_data2[31];
    assign w_mag_a  = w_neg_a ? (32'd0 - read_data1) : read_data1;
    assign w_mag_b  = w_neg_b ? (32'd0 - read_data2) : read_data2;

    logic [32:0] w_mul_sum;
    logic [32:0] w_div_diff;
    logic [63:0] w_acc_next;

    assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
    assign w_div_diff = r_acc[63:31] - {1'b0, r_opnd};
    assign w_acc_next = r_is_div
                      ? (w_div_diff[32] ? {r_acc[62:0], 1'b0}
                                        : {w_div_diff[31:0], r_acc[30:0], 1'b1})
                      : {w_mul_sum, r_acc[31:1]};

    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    assign w_prod = r_neg_q ? (64'd0 - r_acc) : r_acc;
    assign w_quot = r_neg_q ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
    assign w_rem  = r_neg_r ? (32'd0 - r_acc[63:32]) : r_acc[63:32];

    always_comb begin
        w_res_hi = w_prod[63:32];
        w_res_lo = w_prod[31:0];
        if (r_is_div) begin
            if (r_div_zero) begin
                w_res_hi = r_dividend;
                w_res_lo = 32'hFFFF_FFFF;
            end else begin
                w_res_hi = w_rem;
                w_res_lo = w_quot;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 6'd0;
            r_acc      <= 64'd0;
            r_opnd     <= 32'd0;
            r_dividend <= 32'd0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // MTHI/MTLO land whenever the unit is idle, even alongside a start
            if (r_state == S_IDLE && hi_we) r_hi <= wdata;
            if (r_state == S_IDLE && lo_we) r_lo <= wdata;
            if (flush) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_state    <= S_RUN;
                            r_busy     <= 1'b1;
                            r_cnt      <= 6'd0;
                            r_is_div   <= op[1];
                            r_dividend <= read_data1;
                            r_div_zero <= (read_data2 == 32'd0);
                            r_neg_q    <= w_neg_a ^ w_neg_b;
                            r_neg_r    <= w_neg_a;
                            if (op[1]) begin
                                r_acc  <= {32'd0, w_mag_a};
                                r_opnd <= w_mag_b;
                            end else begin
                                r_acc  <= {32'd0, w_mag_b};
                                r_opnd <= w_mag_a;
                            end
                        end
                    end
                    S_RUN: begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt + 6'd1;
                        if (r_cnt == c_LAST_ITER) r_state <= S_FIX;
                    end
                    S_FIX: begin
                        r_hi    <= w_res_hi;
                        r_lo    <= w_res_lo;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign hi_out = r_hi;
    assign lo_out = r_lo;
    assign busy   = r_busy;
    assign done   = r_done;
    assign stall  = r_busy & (hilo_read | start | hi_we | lo_we);

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_muldiv_unit
// Description : Randomised scoreboard bench for ex_muldiv_unit with an
//               arithmetic reference model and directed corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset, start, flush, hilo_read, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] read_data1, read_data2, wdata;
    logic [31:0] hi_out, lo_out;
    logic        busy, done, stall;

    always #5 clk = ~clk;

    ex_muldiv_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .read_data1(read_data1), .read_data2(read_data2), .flush(flush),
        .hilo_read(hilo_read), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done(done), .stall(stall)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          edge_n;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic plus the architectural special cases
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa, sb, q, r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (o)
            2'd0: return sa * sb;
            2'd1: return {32'd0, a} * {32'd0, b};
            2'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
            end else begin
                mon_e = sbq.pop_front();
                chk("hi_result", {32'd0, hi_out}, {32'd0, mon_e.hi});
                chk("lo_result", {32'd0, lo_out}, {32'd0, mon_e.lo});
                chk("done_latency", 64'(cyc), 64'(mon_e.edge_n));
            end
        end
    end

    // Called at posedge+1 with the unit idle; returns at posedge+1 of the done cycle
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit chk_wr, input bit poke);
        exp_t        e;
        logic [63:0] m;
        int          nb;
        bit          got;
        start = 1'b1; op = o; read_data1 = a; read_data2 = b;
        m = model(o, a, b);
        e.hi = m[63:32];
        e.lo = m[31:0];
        e.edge_n = cyc + 34;
        sbq.push_back(e);
        @(posedge clk); #1;
        if (chk_wr) chk("mthi_with_start", {32'd0, hi_out}, {32'd0, wdata});
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        read_data1 = $urandom; read_data2 = $urandom;
        nb = busy ? 1 : 0;
        got = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) nb++;
            if (poke && i == 9) begin
                start = 1'b1; op = 2'($urandom_range(0, 3));
                hi_we = 1'b1; lo_we = 1'b1; wdata = $urandom;
                #1;
                chk("stall_on_busy_start", {63'd0, stall}, 64'd1);
            end
            if (poke && i == 10) begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 40 cycles");
        end
        chk("busy_cycles", 64'(nb), 64'd33);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    logic [31:0] lo_save;
    bit          got34;

    initial begin
        reset = 1'b1; start = 1'b1; flush = 1'b0; hilo_read = 1'b1;
        hi_we = 1'b0; lo_we = 1'b0; op = 2'd0; wdata = 32'd0;
        read_data1 = 32'd5; read_data2 = 32'd6;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hi", {32'd0, hi_out}, 64'd0);
        chk("reset_lo", {32'd0, lo_out}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_stall", {63'd0, stall}, 64'd0);
        start = 1'b0; hilo_read = 1'b0; reset = 1'b0;
        @(posedge clk); #1;

        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("multu_max", {hi_out, lo_out}, 64'hFFFF_FFFE_0000_0001);
        do_op(2'd0, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0, 1'b1);
        chk("mult_neg", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFF1);
        do_op(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0);
        chk("div_neg", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(2'd3, 32'h0000_0007, 32'h0000_0000, 1'b0, 1'b1);
        chk("divu_zero", {hi_out, lo_out}, 64'h0000_0007_FFFF_FFFF);
        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("div_ovf", {hi_out, lo_out}, 64'h0000_0000_8000_0000);

        hi_we = 1'b1; wdata = 32'hAAAA_5555;
        do_op(2'd3, 32'd1000, 32'd33, 1'b1, 1'b0);

        // MTHI then a flushed DIVU
        hi_we = 1'b1; wdata = 32'h1234_5678;
        @(posedge clk); #1;
        hi_we = 1'b0;
        chk("mthi", {32'd0, hi_out}, 64'h1234_5678);
        lo_save = lo_out;
        start = 1'b1; op = 2'd3; read_data1 = 32'd100; read_data2 = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", {63'd0, busy}, 64'd0);
        chk("flush_hi", {32'd0, hi_out}, 64'h1234_5678);
        chk("flush_lo", {32'd0, lo_out}, {32'd0, lo_save});
        repeat (40) @(posedge clk);
        #1;

        // hilo_read stall window on MULTU 3x4
        start = 1'b1; op = 2'd1; read_data1 = 32'd3; read_data2 = 32'd4;
        mon_e.hi = 32'd0; mon_e.lo = 32'd12; mon_e.edge_n = cyc + 34;
        sbq.push_back(mon_e);
        @(posedge clk); #1;
        start = 1'b0;
        got34 = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin
                got34 = 1'b1;
                chk("stall_after_done", {63'd0, stall}, 64'd0);
                chk("multu_3x4_lo", {32'd0, lo_out}, 64'd12);
                break;
            end
            if (i == 4) hilo_read = 1'b1;
            #0;
            if (i >= 5 && i <= 32) chk("stall_hilo_read", {63'd0, stall}, 64'd1);
        end
        hilo_read = 1'b0;
        if (!got34) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done for MULTU 3x4");
        end

        // Reset mid-operation discards it
        @(posedge clk); #1;
        start = 1'b1; op = 2'd0; read_data1 = 32'd77; read_data2 = 32'd99;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midreset_hi", {32'd0, hi_out}, 64'd0);
        chk("midreset_lo", {32'd0, lo_out}, 64'd0);
        chk("midreset_busy", {63'd0, busy}, 64'd0);
        repeat (40) @(posedge clk);
        #1;

        for (int k = 0; k < 40; k++) begin
            do_op(2'($urandom_range(0, 3)), pick(), pick(), 1'b0, (k % 3) == 0);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
